cv32e40x_obi_arbiter: RTL and testbench

- Merges the core's instruction and data OBI master ports onto one shared OBI memory port, for single-ported memory systems.
- Arbitrates address phases round-robin and holds a selection stable while it waits for grant.
- Tracks outstanding transactions in an in-order source-ID FIFO and routes each response back to its issuer.
- Sits between cv32e40x_core (or its wrapper) and the system interconnect.

---
 rtl/cv32e40x_obi_arbiter_if.sv | 51 +++++
 rtl/cv32e40x_obi_arbiter.sv | 108 ++++++++++
 tb/tb_cv32e40x_obi_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_obi_arbiter_if.sv
// rtl/cv32e40x_obi_arbiter_if.sv - OBI bundle: instr/data core ports and the shared memory port
interface cv32e40x_obi_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [5:0]  data_atop_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        data_exokay_o;

  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [5:0]  mem_atop_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        mem_exokay_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_atop_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i, mem_exokay_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, data_exokay_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_atop_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, data_atop_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i, mem_exokay_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, data_exokay_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_atop_o
  );
endinterface

// File: rtl/cv32e40x_obi_arbiter.sv
// rtl/cv32e40x_obi_arbiter.sv - round-robin merge of instr/data OBI ports onto one memory port
// Responses are routed back through an in-order source-ID FIFO.
module cv32e40x_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  cv32e40x_obi_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  logic                       sel_q;
  logic                       lock_q;
  logic                       rr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wptr_q;
  logic [PW-1:0]              rptr_q;
  logic [CW-1:0]              count_q;

  logic sel;
  logic sel_req;
  logic full;
  logic empty;
  logic handshake;
  logic pop;
  logic head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A pending ungranted address phase keeps its source until accepted.
  always_comb begin
    sel = SRC_INSTR;
    if (lock_q) begin
      sel = sel_q;
    end else if (bus.instr_req_i && bus.data_req_i) begin
      sel = ~rr_q;
    end else if (bus.data_req_i) begin
      sel = SRC_DATA;
    end
  end

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign sel_req   = sel ? bus.data_req_i : bus.instr_req_i;
  assign handshake = bus.mem_req_o && bus.mem_gnt_i;
  assign pop       = rst_ni && bus.mem_rvalid_i && !empty;
  assign head      = fifo_q[rptr_q];

  // Full masks the request regardless of a same-cycle pop, so req never depends on rvalid.
  assign bus.mem_req_o   = rst_ni && sel_req && !full;
  assign bus.mem_addr_o  = sel ? bus.data_addr_i : bus.instr_addr_i;
  assign bus.mem_we_o    = sel && bus.data_we_i;
  assign bus.mem_be_o    = sel ? bus.data_be_i : 4'hF;
  assign bus.mem_wdata_o = sel ? bus.data_wdata_i : 32'h0;
  assign bus.mem_atop_o  = sel ? bus.data_atop_i : 6'h0;

  assign bus.instr_gnt_o = handshake && (sel == SRC_INSTR);
  assign bus.data_gnt_o  = handshake && (sel == SRC_DATA);

  assign bus.instr_rvalid_o = pop && (head == SRC_INSTR);
  assign bus.data_rvalid_o  = pop && (head == SRC_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_err_o    = bus.mem_err_i;
  assign bus.data_err_o     = bus.mem_err_i;
  assign bus.data_exokay_o  = bus.mem_exokay_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= SRC_INSTR;
      lock_q  <= 1'b0;
      rr_q    <= SRC_INSTR;
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      lock_q <= bus.mem_req_o && !bus.mem_gnt_i;
      sel_q  <= sel;
      if (handshake) begin
        rr_q           <= sel;
        fifo_q[wptr_q] <= sel;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (handshake && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !handshake) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  stray_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.mem_rvalid_i && empty))
    else $warning("mem_rvalid_i with no outstanding transaction");

endmodule

// File: tb/tb_cv32e40x_obi_arbiter.sv
// tb/tb_cv32e40x_obi_arbiter.sv - directed scoreboard bench for cv32e40x_obi_arbiter
module tb_cv32e40x_obi_arbiter;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  cv32e40x_obi_arbiter_if bus ();

  cv32e40x_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rsp;
    bit          src;
    logic [31:0] val;
    bit          err;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit rsp, input bit src, input logic [31:0] val, input bit err);
    ev_t e;
    e.rsp = rsp;
    e.src = src;
    e.val = val;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic see(input bit rsp, input bit src, input logic [31:0] val, input bit err);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got rsp=%0b src=%0b val=%h err=%0b, none expected",
               rsp, src, val, err);
      return;
    end
    e = exp_q.pop_front();
    if (e.rsp !== rsp || e.src !== src || e.val !== val || e.err !== err) begin
      n_err++;
      $display("FAIL event: got rsp=%0b src=%0b val=%h err=%0b expected rsp=%0b src=%0b val=%h err=%0b",
               rsp, src, val, err, e.rsp, e.src, e.val, e.err);
    end
  endtask

  // Monitor: grants (src/address) and responses (src/rdata/err) against the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.instr_gnt_o && bus.data_gnt_o) begin
        chk("dual_gnt", 32'h1, 32'h0);
      end else if (bus.instr_gnt_o || bus.data_gnt_o) begin
        see(1'b0, bus.data_gnt_o, bus.mem_addr_o, 1'b0);
      end
      if (bus.instr_rvalid_o && bus.data_rvalid_o) begin
        chk("dual_rvalid", 32'h1, 32'h0);
      end else if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
        see(1'b1, bus.data_rvalid_o,
            bus.data_rvalid_o ? bus.data_rdata_o : bus.instr_rdata_o,
            bus.data_rvalid_o ? bus.data_err_o : bus.instr_err_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
    bus.data_atop_i  = 6'h0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    bus.mem_err_i    = 1'b0;
    bus.mem_exokay_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Outputs stay quiet under reset even with active inputs.
    bus.instr_req_i  = 1'b1;
    bus.data_req_i   = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    cyc();
    #1;
    chk("rst_mem_req",      bus.mem_req_o,      32'h0);
    chk("rst_instr_gnt",    bus.instr_gnt_o,    32'h0);
    chk("rst_data_gnt",     bus.data_gnt_o,     32'h0);
    chk("rst_instr_rvalid", bus.instr_rvalid_o, 32'h0);
    chk("rst_data_rvalid",  bus.data_rvalid_o,  32'h0);
    do_reset();

    // Data-only read.
    cyc();
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h100;
    bus.data_be_i   = 4'hF;
    bus.mem_gnt_i   = 1'b1;
    expect_ev(1'b0, 1'b1, 32'h100, 1'b0);
    #1 chk("t1_data_gnt", bus.data_gnt_o, 32'h1);
    cyc();
    idle();
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEADBEEF;
    expect_ev(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    chk("t1_instr_rvalid", bus.instr_rvalid_o, 32'h0);
    chk("t1_data_rvalid",  bus.data_rvalid_o,  32'h1);
    chk("t1_data_rdata",   bus.data_rdata_o,   32'hDEADBEEF);
    cyc();
    idle();

    // Round-robin under continuous contention; data wins first after reset.
    do_reset();
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h2000;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h3000;
    bus.mem_gnt_i    = 1'b1;
    expect_ev(1'b0, 1'b1, 32'h3000, 1'b0);
    #1 chk("t2_first_gnt_data", bus.data_gnt_o, 32'h1);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h11;
    expect_ev(1'b0, 1'b0, 32'h2000, 1'b0);
    expect_ev(1'b1, 1'b1, 32'h11, 1'b0);
    cyc();
    bus.mem_rdata_i = 32'h22;
    expect_ev(1'b0, 1'b1, 32'h3000, 1'b0);
    expect_ev(1'b1, 1'b0, 32'h22, 1'b0);
    cyc();
    bus.mem_rdata_i = 32'h33;
    expect_ev(1'b0, 1'b0, 32'h2000, 1'b0);
    expect_ev(1'b1, 1'b1, 32'h33, 1'b0);
    cyc();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b0;
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rdata_i = 32'h44;
    expect_ev(1'b1, 1'b0, 32'h44, 1'b0);
    cyc();
    idle();

    // Lock: instr waits 3 cycles for grant while data rises behind it.
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h400;
    #1;
    chk("t3_req_c0",  bus.mem_req_o,  32'h1);
    chk("t3_addr_c0", bus.mem_addr_o, 32'h400);
    cyc();
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h500;
    #1 chk("t3_addr_c1", bus.mem_addr_o, 32'h400);
    cyc();
    #1 chk("t3_addr_c2", bus.mem_addr_o, 32'h400);
    cyc();
    bus.mem_gnt_i = 1'b1;
    expect_ev(1'b0, 1'b0, 32'h400, 1'b0);
    #1 chk("t3_instr_gnt", bus.instr_gnt_o, 32'h1);
    cyc();
    bus.instr_req_i = 1'b0;
    expect_ev(1'b0, 1'b1, 32'h500, 1'b0);
    cyc();
    bus.data_req_i   = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hA1;
    expect_ev(1'b1, 1'b0, 32'hA1, 1'b0);
    cyc();
    bus.mem_rdata_i = 32'hA2;
    expect_ev(1'b1, 1'b1, 32'hA2, 1'b0);
    cyc();
    idle();

    // Outstanding limit: full masks req even in the cycle of a pop.
    do_reset();
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h600;
    bus.mem_gnt_i    = 1'b1;
    expect_ev(1'b0, 1'b0, 32'h600, 1'b0);
    cyc();
    expect_ev(1'b0, 1'b0, 32'h600, 1'b0);
    cyc();
    #1 chk("t4_full_req_c0", bus.mem_req_o, 32'h0);
    cyc();
    #1 chk("t4_full_req_c1", bus.mem_req_o, 32'h0);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hB1;
    expect_ev(1'b1, 1'b0, 32'hB1, 1'b0);
    #1 chk("t4_full_pop_req", bus.mem_req_o, 32'h0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    expect_ev(1'b0, 1'b0, 32'h600, 1'b0);
    #1 chk("t4_reopen_req", bus.mem_req_o, 32'h1);
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hB2;
    expect_ev(1'b1, 1'b0, 32'hB2, 1'b0);
    cyc();
    bus.mem_rdata_i = 32'hB3;
    expect_ev(1'b1, 1'b0, 32'hB3, 1'b0);
    cyc();
    idle();

    // Field muxing and in-order responses with error on the second.
    cyc();
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'h3;
    bus.data_wdata_i = 32'hCAFE0000;
    bus.data_atop_i  = 6'h02;
    bus.data_addr_i  = 32'h800;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h700;
    bus.mem_gnt_i    = 1'b1;
    expect_ev(1'b0, 1'b0, 32'h700, 1'b0);
    #1;
    chk("t5_instr_we",    bus.mem_we_o,    32'h0);
    chk("t5_instr_be",    bus.mem_be_o,    32'hF);
    chk("t5_instr_wdata", bus.mem_wdata_o, 32'h0);
    chk("t5_instr_atop",  bus.mem_atop_o,  32'h0);
    cyc();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    expect_ev(1'b0, 1'b1, 32'h800, 1'b0);
    #1;
    chk("t5_data_we",    bus.mem_we_o,    32'h1);
    chk("t5_data_be",    bus.mem_be_o,    32'h3);
    chk("t5_data_wdata", bus.mem_wdata_o, 32'hCAFE0000);
    chk("t5_data_atop",  bus.mem_atop_o,  32'h02);
    cyc();
    bus.data_req_i   = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hC1;
    expect_ev(1'b1, 1'b0, 32'hC1, 1'b0);
    cyc();
    bus.mem_rdata_i  = 32'hC2;
    bus.mem_err_i    = 1'b1;
    bus.mem_exokay_i = 1'b1;
    expect_ev(1'b1, 1'b1, 32'hC2, 1'b1);
    #1 chk("t5_data_exokay", bus.data_exokay_o, 32'h1);
    cyc();
    idle();

    // Reset with two outstanding, then a stray response.
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h900;
    bus.mem_gnt_i    = 1'b1;
    expect_ev(1'b0, 1'b0, 32'h900, 1'b0);
    cyc();
    bus.instr_req_i = 1'b0;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h904;
    expect_ev(1'b0, 1'b1, 32'h904, 1'b0);
    cyc();
    idle();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hD1;
    #1;
    chk("t6_stray_instr_rvalid", bus.instr_rvalid_o, 32'h0);
    chk("t6_stray_data_rvalid",  bus.data_rvalid_o,  32'h0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h980;
    bus.mem_gnt_i    = 1'b1;
    expect_ev(1'b0, 1'b0, 32'h980, 1'b0);
    cyc();
    expect_ev(1'b0, 1'b0, 32'h980, 1'b0);
    cyc();
    #1 chk("t6_count_full", bus.mem_req_o, 32'h0);
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hD2;
    expect_ev(1'b1, 1'b0, 32'hD2, 1'b0);
    cyc();
    bus.mem_rdata_i = 32'hD3;
    expect_ev(1'b1, 1'b0, 32'hD3, 1'b0);
    cyc();
    idle();
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
